regfile_param: RTL and testbench

Parametrised successor to the single-cycle datapath register file: a 2^AW-entry by W-bit register array with NRD asynchronous read ports, one write port, an optional hard-wired zero register and optional write-to-read bypass. It adds a synchronous reset that sweeps every entry to zero through a small clear state machine, and AArch64 W-register writes that zero-extend 32-bit results. It sits between the decode stage (read addresses) and the writeback mux (write data) of the ARMv8 core.

---
 rtl/regfile_param.sv | 218 +++++++++++++++++++++
 tb/tb_regfile_param.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
//
// Parametrised general-purpose register file for the ARMv8 core datapath.
// Sits between decode (read addresses) and the writeback mux (write data).
//
// Features:
//   - 2^AW entries of W bits, NRD independent combinational read ports,
//     one synchronous write port.
//   - Optional hard-wired zero register at entry DEPTH-1 (XZR).
//   - Optional same-cycle write-to-read bypass.
//   - W-register (32-bit) writes that zero-extend Data[31:0].
//   - A synchronous reset that sweeps every entry to zero, one entry per
//     clock, through a two-state CLEAR/RUN machine. Reads return 0 and
//     writes are dropped while the sweep is in progress.
//
// Parameters:
//   W        data width in bits (>= 32 when W32_EN = 1)
//   AW       address width, DEPTH = 2^AW
//   NRD      number of read ports (1..4)
//   ZERO_EN  entry DEPTH-1 reads 0 and ignores writes
//   BYPASS   forward an effective same-cycle write to matching read ports
//   W32_EN   honour i_is32
//
// Ports:
//   i_clk    clock, all state changes on the rising edge
//   i_rst    synchronous active-high reset (restarts the clear sweep)
//   i_raddr  NRD read addresses, port k at [k*AW +: AW]
//   o_rout   NRD read data words, port k at [k*W +: W]
//   i_we     write enable
//   i_wreg   write address
//   i_data   write data
//   i_is32   32-bit write: entry receives {zeros, i_data[31:0]}
//   o_ready  high once the array is cleared and accepting writes
// ---------------------------------------------------------------------------
module regfile_param #(
    parameter int W       = 64,
    parameter int AW      = 5,
    parameter int NRD     = 2,
    parameter bit ZERO_EN = 1'b1,
    parameter bit BYPASS  = 1'b1,
    parameter bit W32_EN  = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NRD*AW-1:0] i_raddr,
    output logic [NRD*W-1:0]  o_rout,
    input  logic              i_we,
    input  logic [AW-1:0]     i_wreg,
    input  logic [W-1:0]      i_data,
    input  logic              i_is32,
    output logic              o_ready
);

    localparam int            DEPTH     = 2 ** AW;
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] CNT_ONE   = AW'(1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Storage and control state
    // -----------------------------------------------------------------------
    logic [W-1:0]  r_mem [DEPTH];
    state_t        r_state;
    logic [AW-1:0] r_cnt;
    logic          r_ready;

    state_t        w_state_nxt;
    logic [AW-1:0] w_cnt_nxt;
    logic          w_clear;      // array is being swept, reads forced to 0
    logic          w_run;        // array accepts writes
    logic          w_eff_we;     // write that actually lands in the array
    logic [W-1:0]  w_wval;       // value written, after optional zero-extend

    // State register: reset forces CLEAR with the sweep counter at 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == ST_RUN);
        end
    end

    // Next-state logic: CLEAR walks cnt over every entry, the edge that
    // clears the last entry enters RUN and the counter wraps back to 0.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_CLEAR: begin
                w_cnt_nxt = r_cnt + CNT_ONE;
                if (r_cnt == ADDR_LAST) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = r_cnt;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode of the state machine.
    always_comb begin
        w_clear = 1'b1;
        w_run   = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clear = 1'b1;
                w_run   = 1'b0;
            end
            ST_RUN: begin
                w_clear = 1'b0;
                w_run   = 1'b1;
            end
            default: begin
                w_clear = 1'b1;
                w_run   = 1'b0;
            end
        endcase
    end

    assign o_ready = r_ready;

    // Effective write qualification; writes to XZR are discarded when the
    // zero register is enabled. Reset is not part of this term, so the
    // bypass path still forwards a write that the reset edge will discard.
    always_comb begin
        if (i_we && w_run) begin
            if (ZERO_EN && (i_wreg == ADDR_LAST)) begin
                w_eff_we = 1'b0;
            end else begin
                w_eff_we = 1'b1;
            end
        end else begin
            w_eff_we = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Write value: W-register writes zero-extend the low 32 bits.
    // -----------------------------------------------------------------------
    generate
        if (W32_EN) begin : g_w32
            function automatic logic [W-1:0] zext32(input logic [W-1:0] d);
                logic [W-1:0] r;
                r       = '0;
                r[31:0] = d[31:0];
                return r;
            endfunction

            // Select zero-extended or full-width write data.
            always_comb begin
                if (i_is32) begin
                    w_wval = zext32(i_data);
                end else begin
                    w_wval = i_data;
                end
            end
        end else begin : g_w64
            assign w_wval = i_data;
        end
    endgenerate

    // Array update: reset wins over everything, the sweep wins over writes
    // (which are dropped, not queued), otherwise apply an effective write.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (w_clear) begin
                r_mem[r_cnt] <= '0;
            end else if (w_eff_we) begin
                r_mem[i_wreg] <= w_wval;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read ports: purely combinational, priority CLEAR > XZR > bypass > array.
    // -----------------------------------------------------------------------
    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd
            logic [AW-1:0] w_ra;
            logic [W-1:0]  w_rdata;

            assign w_ra = i_raddr[k*AW +: AW];

            // Resolve read data for this port.
            always_comb begin
                if (w_clear) begin
                    w_rdata = '0;
                end else if (ZERO_EN && (w_ra == ADDR_LAST)) begin
                    w_rdata = '0;
                end else if (BYPASS && w_eff_we && (i_wreg == w_ra)) begin
                    w_rdata = w_wval;
                end else begin
                    w_rdata = r_mem[w_ra];
                end
            end

            assign o_rout[k*W +: W] = w_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_param.sv
// ---------------------------------------------------------------------------
// tb_regfile_param
//
// Three instances of regfile_param share one stimulus stream:
//   dut 0 : ZERO_EN=1, BYPASS=1
//   dut 1 : ZERO_EN=0, BYPASS=1
//   dut 2 : ZERO_EN=1, BYPASS=0
// Each cycle the stimulus process computes the expected Ready and read data
// for every instance from a behavioural model and queues them; a monitor
// process drains the queue on the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_regfile_param;

    localparam int NDUT = 3;

    logic          clk;
    logic          rst;
    logic [9:0]    raddr;
    logic          we;
    logic [4:0]    wreg;
    logic [63:0]   data;
    logic          is32;
    logic [127:0]  rout [NDUT];
    logic          rdy  [NDUT];

    regfile_param #(.W(64), .AW(5), .NRD(2), .ZERO_EN(1'b1), .BYPASS(1'b1), .W32_EN(1'b1)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_raddr(raddr), .o_rout(rout[0]), .i_we(we),
        .i_wreg(wreg), .i_data(data), .i_is32(is32), .o_ready(rdy[0]));

    regfile_param #(.W(64), .AW(5), .NRD(2), .ZERO_EN(1'b0), .BYPASS(1'b1), .W32_EN(1'b1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_raddr(raddr), .o_rout(rout[1]), .i_we(we),
        .i_wreg(wreg), .i_data(data), .i_is32(is32), .o_ready(rdy[1]));

    regfile_param #(.W(64), .AW(5), .NRD(2), .ZERO_EN(1'b1), .BYPASS(1'b0), .W32_EN(1'b1)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_raddr(raddr), .o_rout(rout[2]), .i_we(we),
        .i_wreg(wreg), .i_data(data), .i_is32(is32), .o_ready(rdy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int          dut;
        int          port;   // -1 = Ready, else read port index
        logic [63:0] exp;
    } chk_t;

    chk_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [63:0] get_out(input int d, input int p);
        if (p < 0) return {63'd0, rdy[d]};
        return rout[d][p*64 +: 64];
    endfunction

    // Monitor: compare every queued expectation against the live outputs.
    always @(negedge clk) begin : monitor
        chk_t        c;
        logic [63:0] act;
        while (sb_q.size() > 0) begin
            c   = sb_q.pop_front();
            act = get_out(c.dut, c.port);
            n_checks++;
            if (act !== c.exp) begin
                n_errors++;
                $display("FAIL %s dut=%0d port=%0d actual=%h required=%h t=%0t",
                         (c.port < 0) ? "ready" : "rout", c.dut, c.port, act, c.exp, $time);
            end
        end
    end

    // ------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------
    bit          cfg_zero [NDUT] = '{1'b1, 1'b0, 1'b1};
    bit          cfg_byp  [NDUT] = '{1'b1, 1'b1, 1'b0};
    logic [63:0] m_mem    [NDUT][32];
    int          m_busy   [NDUT] = '{32, 32, 32};  // clear edges still to go
    bit          chk_on = 1'b0;

    function automatic logic [63:0] m_wval(input logic [63:0] d, input bit i32);
        return i32 ? {32'd0, d[31:0]} : d;
    endfunction

    function automatic bit m_eff(input int m, input bit w, input logic [4:0] wa);
        return w && (m_busy[m] == 0) && !(cfg_zero[m] && (wa == 5'd31));
    endfunction

    function automatic logic [63:0] m_read(input int m, input bit w, input logic [4:0] wa,
                                           input logic [63:0] d, input bit i32,
                                           input logic [4:0] a);
        if (m_busy[m] != 0) return 64'd0;
        if (cfg_zero[m] && (a == 5'd31)) return 64'd0;
        if (cfg_byp[m] && m_eff(m, w, wa) && (wa == a)) return m_wval(d, i32);
        return m_mem[m][a];
    endfunction

    task automatic m_edge(input int m, input bit r, input bit w, input logic [4:0] wa,
                          input logic [63:0] d, input bit i32);
        if (r) begin
            m_busy[m] = 32;
        end else if (m_busy[m] > 0) begin
            m_busy[m] = m_busy[m] - 1;
            if (m_busy[m] == 0) begin
                for (int i = 0; i < 32; i++) m_mem[m][i] = 64'd0;
            end
        end else if (m_eff(m, w, wa)) begin
            m_mem[m][wa] = m_wval(d, i32);
        end
    endtask

    // One clock of stimulus: drive, queue expectations, advance the model.
    task automatic step(input bit r, input bit w, input logic [4:0] wa, input logic [63:0] d,
                        input bit i32, input logic [4:0] a0, input logic [4:0] a1);
        rst   = r;
        we    = w;
        wreg  = wa;
        data  = d;
        is32  = i32;
        raddr = {a1, a0};
        if (chk_on) begin
            for (int m = 0; m < NDUT; m++) begin
                sb_q.push_back('{m, -1, (m_busy[m] == 0) ? 64'd1 : 64'd0});
                sb_q.push_back('{m, 0, m_read(m, w, wa, d, i32, a0)});
                sb_q.push_back('{m, 1, m_read(m, w, wa, d, i32, a1)});
            end
        end
        @(posedge clk);
        for (int m = 0; m < NDUT; m++) m_edge(m, r, w, wa, d, i32);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        rst = 1'b1; we = 1'b0; wreg = 5'd0; data = 64'd0; is32 = 1'b0; raddr = 10'd0;
        @(posedge clk);
        #1;
        // First reset: outputs undefined before it, so no checks this cycle.
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);
        chk_on = 1'b1;
        for (int i = 0; i < 33; i++)
            step(1'b0, 1'b1, 5'(i), rnd64(), 1'b0, 5'(i), 5'(31 - i));

        // Preload every entry with random data.
        for (int a = 0; a < 32; a++)
            step(1'b0, 1'b1, 5'(a), rnd64(), 1'b0, 5'(a), 5'((a + 31) % 32));

        // Reset sweep with WE held high throughout the clear.
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd1, 5'd2);
        for (int i = 0; i < 32; i++)
            step(1'b0, 1'b1, 5'($urandom_range(0, 31)), rnd64(), 1'b0, 5'(i), 5'(31 - i));
        for (int a = 0; a < 32; a += 2)
            step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'(a), 5'(a + 1));

        // Basic write/read on X3.
        step(1'b0, 1'b1, 5'd3, 64'h0123_4567_89AB_CDEF, 1'b0, 5'd0, 5'd1);
        step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd3, 5'd3);

        // W-register write zero-extends.
        step(1'b0, 1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd5, 5'd4);
        step(1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF_1234_5678, 1'b1, 5'd5, 5'd3);
        step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd5, 5'd5);

        // Zero register: same cycle and next cycle.
        step(1'b0, 1'b1, 5'd31, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 5'd31, 5'd3);
        step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd31, 5'd31);

        // Bypass versus read-before-write.
        step(1'b0, 1'b1, 5'd7, 64'h11, 1'b0, 5'd6, 5'd8);
        step(1'b0, 1'b1, 5'd7, 64'h22, 1'b0, 5'd7, 5'd7);
        step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd7, 5'd7);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 199) == 0), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
                 rnd64(), $urandom_range(0, 1), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        for (int i = 0; i < 40; i++)
            step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

        // Reset coinciding with a RUN-state write, then Rst held, then
        // Rst reasserted 10 cycles into the sweep.
        step(1'b0, 1'b1, 5'd9, 64'h5555_0000_5555_0000, 1'b0, 5'd9, 5'd0);
        step(1'b1, 1'b1, 5'd9, 64'h9999_9999_9999_9999, 1'b0, 5'd9, 5'd9);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 5'(i), rnd64(), 1'b0, 5'(i), 5'd9);
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, 5'(i), rnd64(), 1'b0, 5'(i), 5'd9);
        step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd9, 5'd3);
        for (int i = 0; i < 34; i++)
            step(1'b0, 1'b1, 5'(i), rnd64(), 1'b0, 5'(i % 32), 5'd9);
        for (int a = 0; a < 32; a += 2)
            step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'(a), 5'(a + 1));

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
